brick_field: RTL and testbench

- Writer side of the brick map that the LED scan display reads.
- Stores two rows of eight bricks and answers ball-position hit queries from the game logic through a valid/ready handshake.
- Clears each hit brick, keeps a score and brick count, and flags when the field is empty.
- Publishes the live brick vectors, 1 = brick present, for the display to sample.

---
 rtl/brick_pkg.sv | 21 ++
 rtl/brick_popcount.sv | 20 ++
 rtl/brick_field.sv | 147 ++++++++++++++
 tb/tb_brick_field.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/brick_pkg.sv
// brick_pkg: shared types and constants for the brick map writer.
// State encoding, row-select encoding and the full-row pattern used on
// reset and refill.
package brick_pkg;

    typedef enum logic [1:0] {
        IDLE,
        LOOKUP,
        RESPOND,
        EMPTY
    } state_t;

    localparam int BRICK_ROWS = 2;
    localparam int MAP_COLS   = 8;

    localparam logic [MAP_COLS-1:0] FULL_ROW = '1;

    localparam logic ROW_TOP = 1'b0;
    localparam logic ROW_BOT = 1'b1;

endpackage

// File: rtl/brick_popcount.sv
// brick_popcount: combinational population count of the brick bits,
// used to cross-check the registered brick counter.
module brick_popcount #(
    parameter int N = 16,
    parameter int W = $clog2(N + 1)
) (
    input  logic [N-1:0] bits,
    output logic [W-1:0] count
);

    // Sum every brick bit.
    always_comb begin
        // NOTE: count gets a value before the loop so every path assigns it and no latch is inferred.
        count = '0;
        for (int i = 0; i < N; i++) begin
            count = count + W'(bits[i]);
        end
    end

endmodule

// File: rtl/brick_field.sv
// brick_field: writer side of the brick map read by the LED scan display.
// Answers ball-position hit queries over a valid/ready handshake, clears hit
// bricks, keeps score and brick count, and flags an empty field.
// Optional feature: define BRICK_REFILL_EN to refill the field REFILL_DELAY
// cycles after it empties and count levels; otherwise EMPTY is terminal.
module brick_field
    import brick_pkg::*;
#(
    parameter int COLS      = MAP_COLS,
    parameter int TOP_Y     = 7,
    parameter int SCORE_W   = 8,
    parameter int SCORE_INC = 1
`ifdef BRICK_REFILL_EN
    ,
    parameter int REFILL_DELAY = 20
`endif
) (
    input  logic               buttonclk,
    input  logic               reset,
    input  logic               check_valid,
    output logic               check_ready,
    input  logic [2:0]         ball_x,
    input  logic [2:0]         ball_y,
    output logic               hit_valid,
    output logic               hit,
    output logic               hit_row,
    output logic [COLS-1:0]    bricks_top,
    output logic [COLS-1:0]    bricks_bot,
    output logic [4:0]         bricks_left,
    output logic [SCORE_W-1:0] score,
    output logic               all_clear,
    output logic [3:0]         level
);

    localparam int          SW1        = SCORE_W + 1;
    localparam logic [4:0]  FULL_COUNT = 5'(BRICK_ROWS * COLS);

    state_t       state;
    logic [2:0]   cap_x;
    logic [2:0]   cap_y;
    logic         sel_top;
    logic         sel_bot;
    logic [SW1-1:0] score_sum;
    logic [4:0]   pop_count;

    // Row decode works on the captured coordinates only, so the ball may
    // move freely once the query has been accepted.
    assign sel_top   = (cap_y == 3'(TOP_Y));
    assign sel_bot   = (cap_y == 3'(TOP_Y - 1));
    assign score_sum = {1'b0, score} + SW1'(SCORE_INC);

`ifdef BRICK_REFILL_EN
    localparam int CNT_W = $clog2(REFILL_DELAY + 1);
    logic [CNT_W-1:0] refill_cnt;
`else
    assign level = 4'd0;
`endif

    // Query FSM with registered handshake, response and map outputs.
    always_ff @(posedge buttonclk) begin
        // NOTE: every register here uses <= so all state updates see the pre-edge values.
        if (reset) begin
            state       <= IDLE;
            check_ready <= 1'b1;
            hit_valid   <= 1'b0;
            hit         <= 1'b0;
            hit_row     <= ROW_TOP;
            cap_x       <= 3'd0;
            cap_y       <= 3'd0;
            bricks_top  <= FULL_ROW[COLS-1:0];
            bricks_bot  <= FULL_ROW[COLS-1:0];
            bricks_left <= FULL_COUNT;
            score       <= '0;
            all_clear   <= 1'b0;
`ifdef BRICK_REFILL_EN
            level       <= 4'd0;
            refill_cnt  <= '0;
`endif
        end else begin
            hit_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (check_valid) begin
                        cap_x       <= ball_x;
                        cap_y       <= ball_y;
                        check_ready <= 1'b0;
                        state       <= LOOKUP;
                    end
                end
                LOOKUP: begin
                    hit       <= (sel_top & bricks_top[cap_x]) | (sel_bot & bricks_bot[cap_x]);
                    hit_row   <= sel_bot ? ROW_BOT : ROW_TOP;
                    hit_valid <= 1'b1;
                    state     <= RESPOND;
                end
                RESPOND: begin
                    // hit is only set for a present brick, so the count cannot underflow.
                    if (hit) begin
                        if (hit_row == ROW_TOP) bricks_top[cap_x] <= 1'b0;
                        else                    bricks_bot[cap_x] <= 1'b0;
                        bricks_left <= bricks_left - 5'd1;
                        score       <= score_sum[SCORE_W] ? '1 : score_sum[SCORE_W-1:0];
                    end
                    if (hit && bricks_left == 5'd1) begin
                        all_clear <= 1'b1;
                        state     <= EMPTY;
                    end else begin
                        check_ready <= 1'b1;
                        state       <= IDLE;
                    end
                end
                EMPTY: begin
`ifdef BRICK_REFILL_EN
                    if (refill_cnt == CNT_W'(REFILL_DELAY - 1)) begin
                        refill_cnt  <= '0;
                        bricks_top  <= FULL_ROW[COLS-1:0];
                        bricks_bot  <= FULL_ROW[COLS-1:0];
                        bricks_left <= FULL_COUNT;
                        all_clear   <= 1'b0;
                        level       <= level + 4'd1;
                        check_ready <= 1'b1;
                        state       <= IDLE;
                    end else begin
                        refill_cnt <= refill_cnt + CNT_W'(1);
                    end
`else
                    state <= EMPTY;
`endif
                end
                default: state <= IDLE;
            endcase
        end
    end

    brick_popcount #(
        .N (BRICK_ROWS * COLS),
        .W (5)
    ) u_popcount (
        .bits  ({bricks_top, bricks_bot}),
        .count (pop_count)
    );

    // The registered count must always track the live map.
    count_matches_map: assert property (@(posedge buttonclk) disable iff (reset)
        bricks_left == pop_count);

endmodule

// File: tb/tb_brick_field.sv
// tb_brick_field: directed self-checking bench for brick_field.
// Covers reset, hit/miss/repeat queries, busy-time query rejection, a full
// field clear, the EMPTY behaviour of the current build and a mid-query reset.
module tb_brick_field;

    logic       buttonclk = 1'b0;
    logic       reset = 1'b1;
    logic       check_valid = 1'b0;
    logic       check_ready;
    logic [2:0] ball_x = 3'd0;
    logic [2:0] ball_y = 3'd0;
    logic       hit_valid;
    logic       hit;
    logic       hit_row;
    logic [7:0] bricks_top;
    logic [7:0] bricks_bot;
    logic [4:0] bricks_left;
    logic [7:0] score;
    logic       all_clear;
    logic [3:0] level;

    int n_cmp = 0;
    int n_bad = 0;
    int hv_pulses = 0;

    brick_field dut (
        .buttonclk   (buttonclk),
        .reset       (reset),
        .check_valid (check_valid),
        .check_ready (check_ready),
        .ball_x      (ball_x),
        .ball_y      (ball_y),
        .hit_valid   (hit_valid),
        .hit         (hit),
        .hit_row     (hit_row),
        .bricks_top  (bricks_top),
        .bricks_bot  (bricks_bot),
        .bricks_left (bricks_left),
        .score       (score),
        .all_clear   (all_clear),
        .level       (level)
    );

    always #5 buttonclk = ~buttonclk;

    // hit_valid is a one-cycle strobe, so each pulse is seen at exactly one falling edge.
    always @(negedge buttonclk) if (hit_valid === 1'b1) hv_pulses++;

    task automatic step();
        @(posedge buttonclk);
        #1;
    endtask

    // Waits (bounded) for check_ready, issues one query, scrambles the ball
    // inputs after acceptance and returns the response seen one and two edges later.
    task automatic query(input logic [2:0] x, input logic [2:0] y,
                         output logic hv1, output logic hit1, output logic row1,
                         output logic hv2);
        bit ok = 1'b0;
        hv1 = 1'b0; hit1 = 1'b0; row1 = 1'b0; hv2 = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (check_ready === 1'b1) begin
                ok = 1'b1;
                break;
            end
            step();
        end
        n_cmp++;
        if (!ok) begin
            n_bad++;
            $display("FAIL query_ready x=%0d y=%0d: check_ready=%b, required 1", x, y, check_ready);
            return;
        end
        check_valid = 1'b1; ball_x = x; ball_y = y;
        step();
        check_valid = 1'b0; ball_x = ~x; ball_y = ~y;
        step();
        hv1 = hit_valid; hit1 = hit; row1 = hit_row;
        step();
        hv2 = hit_valid;
    endtask

    task automatic test_reset();
        reset = 1'b1; check_valid = 1'b0;
        step(); step();
        reset = 1'b0;
        n_cmp++;
        if ({bricks_top, bricks_bot} !== 16'hFFFF) begin
            n_bad++; $display("FAIL reset_bricks: got %h, required ffff", {bricks_top, bricks_bot});
        end
        n_cmp++;
        if (bricks_left !== 5'd16) begin
            n_bad++; $display("FAIL reset_left: got %0d, required 16", bricks_left);
        end
        n_cmp++;
        if ({score, level, all_clear} !== 13'd0) begin
            n_bad++; $display("FAIL reset_score_level_clear: got score=%0d level=%0d all_clear=%b, required 0/0/0",
                              score, level, all_clear);
        end
        n_cmp++;
        if ({hit_valid, hit, hit_row, check_ready} !== 4'b0001) begin
            n_bad++; $display("FAIL reset_handshake: got hv/hit/row/ready=%b, required 0001",
                              {hit_valid, hit, hit_row, check_ready});
        end
    endtask

    task automatic test_first_hit();
        logic hv1, h, r, hv2;
        query(3'd3, 3'd7, hv1, h, r, hv2);
        n_cmp++;
        if ({hv1, h, r, hv2} !== 4'b1100) begin
            n_bad++; $display("FAIL first_hit_resp: got hv1/hit/row/hv2=%b, required 1100", {hv1, h, r, hv2});
        end
        n_cmp++;
        if (bricks_top !== 8'b1111_0111) begin
            n_bad++; $display("FAIL first_hit_top: got %b, required 11110111", bricks_top);
        end
        n_cmp++;
        if (bricks_left !== 5'd15 || score !== 8'd1) begin
            n_bad++; $display("FAIL first_hit_count: got left=%0d score=%0d, required 15/1", bricks_left, score);
        end
    endtask

    task automatic test_repeat_hit();
        logic hv1, h, r, hv2;
        query(3'd3, 3'd7, hv1, h, r, hv2);
        n_cmp++;
        if ({hv1, h} !== 2'b10) begin
            n_bad++; $display("FAIL repeat_resp: got hv1/hit=%b, required 10", {hv1, h});
        end
        n_cmp++;
        if (bricks_left !== 5'd15 || score !== 8'd1) begin
            n_bad++; $display("FAIL repeat_count: got left=%0d score=%0d, required 15/1", bricks_left, score);
        end
    endtask

    task automatic test_miss();
        logic hv1, h, r, hv2;
        query(3'd5, 3'd2, hv1, h, r, hv2);
        n_cmp++;
        if ({hv1, h} !== 2'b10) begin
            n_bad++; $display("FAIL miss_resp: got hv1/hit=%b, required 10", {hv1, h});
        end
        n_cmp++;
        if ({bricks_top, bricks_bot} !== 16'hF7FF || bricks_left !== 5'd15 || score !== 8'd1) begin
            n_bad++; $display("FAIL miss_state: got map=%h left=%0d score=%0d, required f7ff/15/1",
                              {bricks_top, bricks_bot}, bricks_left, score);
        end
    endtask

    task automatic test_busy_ignored();
        int p0 = hv_pulses;
        check_valid = 1'b1; ball_x = 3'd0; ball_y = 3'd7;
        step();                               // accepted
        ball_x = 3'd1; ball_y = 3'd6;         // held valid through LOOKUP and RESPOND
        step();
        step();
        check_valid = 1'b0;
        repeat (3) step();
        n_cmp++;
        if (hv_pulses - p0 !== 1) begin
            n_bad++; $display("FAIL busy_pulses: got %0d hit_valid pulses, required 1", hv_pulses - p0);
        end
        n_cmp++;
        if ({bricks_top, bricks_bot} !== 16'hF6FF || bricks_left !== 5'd14 || score !== 8'd2) begin
            n_bad++; $display("FAIL busy_state: got map=%h left=%0d score=%0d, required f6ff/14/2",
                              {bricks_top, bricks_bot}, bricks_left, score);
        end
    endtask

    task automatic test_full_clear();
        logic [7:0] exp_top = 8'hF6;
        logic [7:0] exp_bot = 8'hFF;
        logic hv1, h, r, hv2, exp_hit;
        for (int row = 0; row < 2; row++) begin
            for (int x = 0; x < 8; x++) begin
                exp_hit = (row == 0) ? exp_top[x] : exp_bot[x];
                query(3'(x), (row == 0) ? 3'd7 : 3'd6, hv1, h, r, hv2);
                n_cmp++;
                if ({hv1, h} !== {1'b1, exp_hit}) begin
                    n_bad++; $display("FAIL clear_hit row=%0d x=%0d: got hv1/hit=%b, required 1%b",
                                      row, x, {hv1, h}, exp_hit);
                end
                if (row == 0) exp_top[x] = 1'b0;
                else          exp_bot[x] = 1'b0;
            end
        end
        n_cmp++;
        if ({all_clear, check_ready} !== 2'b10 || {bricks_top, bricks_bot} !== 16'h0000) begin
            n_bad++; $display("FAIL clear_flags: got all_clear/ready=%b map=%h, required 10/0000",
                              {all_clear, check_ready}, {bricks_top, bricks_bot});
        end
        n_cmp++;
        if (bricks_left !== 5'd0 || score !== 8'd16) begin
            n_bad++; $display("FAIL clear_count: got left=%0d score=%0d, required 0/16", bricks_left, score);
        end
    endtask

`ifdef BRICK_REFILL_EN
    task automatic test_empty();
        repeat (19) step();
        n_cmp++;
        if ({all_clear, check_ready, level} !== 6'b10_0000) begin
            n_bad++; $display("FAIL refill_early: got all_clear/ready/level=%b, required 100000",
                              {all_clear, check_ready, level});
        end
        step();
        n_cmp++;
        if ({bricks_top, bricks_bot} !== 16'hFFFF || bricks_left !== 5'd16) begin
            n_bad++; $display("FAIL refill_map: got map=%h left=%0d, required ffff/16",
                              {bricks_top, bricks_bot}, bricks_left);
        end
        n_cmp++;
        if (level !== 4'd1 || score !== 8'd16 || {all_clear, check_ready} !== 2'b01) begin
            n_bad++; $display("FAIL refill_state: got level=%0d score=%0d clear/ready=%b, required 1/16/01",
                              level, score, {all_clear, check_ready});
        end
    endtask
`else
    task automatic test_empty();
        int p0 = hv_pulses;
        check_valid = 1'b1; ball_x = 3'd0; ball_y = 3'd7;
        repeat (25) step();
        check_valid = 1'b0;
        n_cmp++;
        if (hv_pulses - p0 !== 0) begin
            n_bad++; $display("FAIL empty_pulses: got %0d hit_valid pulses, required 0", hv_pulses - p0);
        end
        n_cmp++;
        if ({all_clear, check_ready, level} !== 6'b10_0000 || bricks_left !== 5'd0) begin
            n_bad++; $display("FAIL empty_hold: got clear/ready/level=%b left=%0d, required 100000/0",
                              {all_clear, check_ready, level}, bricks_left);
        end
    endtask
`endif

    task automatic test_reset_mid_query();
        logic hv1, h, r, hv2;
        int p0;
        reset = 1'b1; step(); reset = 1'b0;
        query(3'd2, 3'd6, hv1, h, r, hv2);
        n_cmp++;
        if ({hv1, h, r} !== 3'b111 || bricks_bot !== 8'hFB || score !== 8'd1) begin
            n_bad++; $display("FAIL pre_reset_hit: got hv1/hit/row=%b bot=%h score=%0d, required 111/fb/1",
                              {hv1, h, r}, bricks_bot, score);
        end
        check_valid = 1'b1; ball_x = 3'd0; ball_y = 3'd6;
        step();                               // accepted, now in LOOKUP
        check_valid = 1'b0;
        p0 = hv_pulses;
        reset = 1'b1;
        step();
        reset = 1'b0;
        repeat (3) step();
        n_cmp++;
        if (hv_pulses - p0 !== 0) begin
            n_bad++; $display("FAIL reset_mid_pulses: got %0d hit_valid pulses, required 0", hv_pulses - p0);
        end
        n_cmp++;
        if (bricks_bot !== 8'hFF || score !== 8'd0 || bricks_left !== 5'd16 || check_ready !== 1'b1) begin
            n_bad++; $display("FAIL reset_mid_state: got bot=%h score=%0d left=%0d ready=%b, required ff/0/16/1",
                              bricks_bot, score, bricks_left, check_ready);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached before the summary");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_first_hit();
        test_repeat_hit();
        test_miss();
        test_busy_ignored();
        test_full_clear();
        test_empty();
        test_reset_mid_query();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
